// File: rtl/triangle_aabb_clip_if.sv
// Triangle-in / bounding-box-out handshake bundle for triangle_aabb_clip.
// Latency: none; this is only wiring shared by the unit and its neighbours.
// Backpressure: valid/ready on both sides (aValid/anOutReady in, anOutValid/aReady out).
//
// Ports grouped here:
//   aValid, aPoint1..3, aViewportMax, aReady             driven by the environment
//   anOutReady, anOutValid, anOutMin, anOutMax,
//   anOutCulled, anOutCulledCount                        driven by the unit
// Vertex [0] is x and [1] is y. Points are signed; viewport and box corners are unsigned.
interface triangle_aabb_clip_if #(
    parameter int COORD_W = 12,
    parameter int CNT_W   = 16
);
    logic                           aValid;
    logic                           anOutReady;
    logic [1:0][COORD_W-1:0]        aPoint1;
    logic [1:0][COORD_W-1:0]        aPoint2;
    logic [1:0][COORD_W-1:0]        aPoint3;
    logic [1:0][COORD_W-2:0]        aViewportMax;
    logic                           aReady;
    logic                           anOutValid;
    logic [1:0][COORD_W-2:0]        anOutMin;
    logic [1:0][COORD_W-2:0]        anOutMax;
    logic                           anOutCulled;
    logic [CNT_W-1:0]               anOutCulledCount;

    // environment side: supplies triangles, consumes boxes
    modport master (
        output aValid, aPoint1, aPoint2, aPoint3, aViewportMax, aReady,
        input  anOutReady, anOutValid, anOutMin, anOutMax, anOutCulled, anOutCulledCount
    );

    // unit side
    modport slave (
        input  aValid, aPoint1, aPoint2, aPoint3, aViewportMax, aReady,
        output anOutReady, anOutValid, anOutMin, anOutMax, anOutCulled, anOutCulledCount
    );
endinterface

// File: rtl/triangle_aabb_clip.sv
// Triangle bounding box, clipped to the viewport, with off-screen cull flag and saturating cull counter.
// Latency: 2 cycles (stage 1 raw min/max, stage 2 clip/cull registers the outputs); 1 triangle/cycle.
// Backpressure: holds up to 2 triangles while aReady=0; anOutReady drops once both stages are full.
//
// Ports: aClock, aReset (synchronous, active high), io (triangle_aabb_clip_if.slave).
// Build option: define TRIANGLE_AABB_TILE_ALIGN_EN to snap non-culled boxes outward to
// 2^TILE_SHIFT pixel tiles (min rounded down, max rounded up and capped at the viewport).
module triangle_aabb_clip #(
    parameter int COORD_W    = 12,
    parameter int TILE_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 aClock,
    input  logic                 aReset,
    triangle_aabb_clip_if.slave  io
);

`ifdef TRIANGLE_AABB_TILE_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    localparam int UW = COORD_W - 1;   // unsigned viewport / box width
    localparam int EW = COORD_W + 1;   // common signed compare width
    localparam logic [UW-1:0] TILE_MASK = UW'((1 << TILE_SHIFT) - 1);

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [EW-1:0]      ext_t;
    typedef logic [UW-1:0]             ucoord_t;

    function automatic coord_t smin3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t smax3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic ext_t sext(input coord_t v);
        return {v[COORD_W-1], v};
    endfunction

    function automatic ext_t zext(input ucoord_t v);
        return {2'b00, v};
    endfunction

    // clamp(v, 0, vp); any value that survives both tests fits in UW bits
    function automatic ucoord_t clamp(input ext_t v, input ext_t vp);
        if (v[EW-1])
            return '0;
        else if (v > vp)
            return vp[UW-1:0];
        else
            return v[UW-1:0];
    endfunction

    // stage 1: raw signed extents plus the viewport captured alongside them
    logic    s1_vld;
    coord_t  s1_minx, s1_miny, s1_maxx, s1_maxy;
    ucoord_t s1_vpx, s1_vpy;

    // stage 2: output registers
    logic             s2_vld;
    ucoord_t          s2_minx, s2_miny, s2_maxx, s2_maxy;
    logic             s2_culled;
    logic [CNT_W-1:0] cull_cnt;

    logic out_fire, s1_adv, in_rdy, in_fire;

    assign out_fire = s2_vld && io.aReady;
    assign s1_adv   = s1_vld && (!s2_vld || io.aReady);
    assign in_rdy   = !aReset && (!s1_vld || s1_adv);
    assign in_fire  = io.aValid && in_rdy;

    // stage 2 combinational clip / cull / align
    ucoord_t c_minx, c_miny, c_maxx, c_maxy;
    ucoord_t t_maxx, t_maxy;
    logic    c_culled;
    ext_t    vpx_e, vpy_e;

    always_comb begin
        vpx_e    = zext(s1_vpx);
        vpy_e    = zext(s1_vpy);
        c_culled = (sext(s1_minx) > vpx_e) || (sext(s1_miny) > vpy_e)
                || s1_maxx[COORD_W-1] || s1_maxy[COORD_W-1];
        c_minx   = clamp(sext(s1_minx), vpx_e);
        c_miny   = clamp(sext(s1_miny), vpy_e);
        c_maxx   = clamp(sext(s1_maxx), vpx_e);
        c_maxy   = clamp(sext(s1_maxy), vpy_e);
        t_maxx   = c_maxx | TILE_MASK;
        t_maxy   = c_maxy | TILE_MASK;
        // culled boxes are don't-care downstream, so alignment skips them
        if (ALIGN_EN && !c_culled) begin
            c_minx = c_minx & ~TILE_MASK;
            c_miny = c_miny & ~TILE_MASK;
            c_maxx = (t_maxx > s1_vpx) ? s1_vpx : t_maxx;
            c_maxy = (t_maxy > s1_vpy) ? s1_vpy : t_maxy;
        end
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            s1_vld  <= 1'b0;
            s1_minx <= '0;
            s1_miny <= '0;
            s1_maxx <= '0;
            s1_maxy <= '0;
            s1_vpx  <= '0;
            s1_vpy  <= '0;
        end else if (in_fire) begin
            s1_vld  <= 1'b1;
            s1_minx <= smin3(coord_t'(io.aPoint1[0]), coord_t'(io.aPoint2[0]), coord_t'(io.aPoint3[0]));
            s1_miny <= smin3(coord_t'(io.aPoint1[1]), coord_t'(io.aPoint2[1]), coord_t'(io.aPoint3[1]));
            s1_maxx <= smax3(coord_t'(io.aPoint1[0]), coord_t'(io.aPoint2[0]), coord_t'(io.aPoint3[0]));
            s1_maxy <= smax3(coord_t'(io.aPoint1[1]), coord_t'(io.aPoint2[1]), coord_t'(io.aPoint3[1]));
            s1_vpx  <= io.aViewportMax[0];
            s1_vpy  <= io.aViewportMax[1];
        end else if (s1_adv) begin
            s1_vld  <= 1'b0;
        end
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            s2_vld    <= 1'b0;
            s2_minx   <= '0;
            s2_miny   <= '0;
            s2_maxx   <= '0;
            s2_maxy   <= '0;
            s2_culled <= 1'b0;
        end else if (s1_adv) begin
            s2_vld    <= 1'b1;
            s2_minx   <= c_minx;
            s2_miny   <= c_miny;
            s2_maxx   <= c_maxx;
            s2_maxy   <= c_maxy;
            s2_culled <= c_culled;
        end else if (out_fire) begin
            // data left as-is; only the valid bit drops
            s2_vld    <= 1'b0;
        end
    end

    always_ff @(posedge aClock) begin
        if (aReset)
            cull_cnt <= '0;
        else if (out_fire && s2_culled && (cull_cnt != {CNT_W{1'b1}}))
            cull_cnt <= cull_cnt + 1'b1;
    end

    assign io.anOutReady       = in_rdy;
    assign io.anOutValid       = s2_vld;
    assign io.anOutMin[0]      = s2_minx;
    assign io.anOutMin[1]      = s2_miny;
    assign io.anOutMax[0]      = s2_maxx;
    assign io.anOutMax[1]      = s2_maxy;
    assign io.anOutCulled      = s2_culled;
    assign io.anOutCulledCount = cull_cnt;

endmodule

// File: doc/triangle_aabb_clip.md
# triangle_aabb_clip

Pipelined, parametrised triangle bounding-box unit for the rasteriser front end. It accepts one screen-space triangle per cycle over a valid/ready handshake and computes its axis-aligned bounding box. The box is clipped to the current viewport and flagged as culled when it lies entirely off-screen. Results go to the tile/span walker, and a saturating culled-triangle counter feeds the debug status registers.

## Interface
- COORD_W, 12: width of the signed two's-complement input vertex coordinates.
- TILE_SHIFT, 3: log2 of the tile edge in pixels; used only when tile alignment is compiled in.
- CNT_W, 16: width of the culled-triangle counter.

Clock and reset are one clock with a synchronous, active-high reset.
- aClock  in  1  clock.
- aReset  in  1  synchronous active-high reset.
- aValid  in  1  upstream triangle valid.
- anOutReady  out  1  this block can accept a triangle this cycle.
- aPoint1, aPoint2, aPoint3  in  COORD_W x [2]  signed vertex [0]=x, [1]=y.
- aViewportMax  in  COORD_W-1 x [2]  unsigned inclusive viewport maximum x/y; the viewport minimum is fixed at 0.
- aReady  in  1  downstream accepts the output.
- anOutValid  out  1  output box valid.
- anOutMin, anOutMax  out  COORD_W-1 x [2]  unsigned clipped box corners, inclusive.
- anOutCulled  out  1  box lies fully outside the viewport.
- anOutCulledCount  out  CNT_W  saturating count of culled triangles delivered.

## Operation
- Input handshake fires when aValid && anOutReady. Points and aViewportMax are captured together in stage 1. Later viewport changes do not affect in-flight triangles.
- Stage 1 computes the raw signed min/max per axis over the 3 vertices. Ties may select any equal vertex, since the value is identical.
- Stage 2 computes culled = (rawMinX > vpX) | (rawMinY > vpY) | (rawMaxX < 0) | (rawMaxY < 0).
- Stage 2 clipping:
  - min = clamp(rawMin, 0, vp).
  - max = clamp(rawMax, 0, vp).
  - All comparisons are signed at COORD_W+1 bits; vp is zero-extended.
- Culled triangles are still emitted, with anOutCulled=1. Their min/max are the clamped values, which are don't-care for downstream.
- Output handshake fires when anOutValid && aReady. The culled counter increments by 1 when this fires with anOutCulled=1. It saturates at 2^CNT_W-1 and does not wrap.
- Pipeline control, with each stage holding a valid bit:
  - A stage loads when it is empty or its contents move on in the same cycle.
  - anOutReady = !s1Valid || (s1 advances this cycle). This is combinational from stage state and aReady.
- Data order is strictly preserved. No triangle is dropped or duplicated under any aValid/aReady pattern.
- Degenerate triangles (all vertices equal, or collinear) are handled normally and produce zero-width or zero-height boxes.

## Timing
- Latency: a triangle accepted at edge N appears on anOutValid after edge N+2 when there is no stall.
- Throughput: 1 triangle/cycle while aReady=1.
- Stall: with aReady=0, at most 2 triangles are held and anOutReady falls once both stages are full. anOutMin/Max/Culled stay stable while anOutValid=1 and aReady=0.
- Simultaneous accept and deliver in one cycle with full stages is legal and sustains full rate.
- Reset, applied at any cycle including mid-stall:
  - Both valid bits clear, and any in-flight triangles are discarded.
  - anOutValid=0, anOutMin=anOutMax=0, anOutCulled=0, anOutCulledCount=0.
  - anOutReady=0 while aReset=1, and 1 on the first cycle after release.

## Configuration
- Macro: TRIANGLE_AABB_TILE_ALIGN_EN.
- Defined: after clipping, tile alignment is applied to non-culled boxes.
  - min is rounded down: min & ~(2^TILE_SHIFT-1).
  - max is rounded up: min(max | (2^TILE_SHIFT-1), vp).
  - Alignment adds no extra latency; stage 2 absorbs it.
- Undefined: outputs are the exact clipped box, and TILE_SHIFT is unused.

## Test plan
All scenarios use COORD_W=12, viewport (639,479), TILE_ALIGN off unless stated.
- Basic: (10,20),(30,5),(15,40), aReady=1 -> anOutValid 2 cycles after accept; min (10,5), max (30,40), culled 0.
- Clipping: (-5,-7),(700,100),(50,500) -> min (0,0), max (639,479), culled 0.
- Cull and count:
  - (700,10),(800,20),(650,30) -> culled 1, anOutCulledCount 0->1.
  - (-9,-9),(-1,-3),(-2,-2) -> culled 1, count 2.
- Backpressure: send 4 triangles back-to-back with aReady=0 for 6 cycles, then 1 -> anOutReady low after 2 accepts; all 4 delivered in order with no loss or duplicate; outputs stable while stalled.
- Reset mid-stall: assert aReset for 1 cycle with 2 triangles held -> next cycle anOutValid=0, count=0, all outputs 0; a fresh triangle gives its correct box 2 cycles after accept.
- Tile alignment: with TRIANGLE_AABB_TILE_ALIGN_EN defined, (10,20),(30,5),(15,40) -> min (8,0), max (31,47). Also (600,400),(639,479),(620,450) -> min (600,400), max (639,479), capped at the viewport.
